// File: rtl/key_move_scheduler_if.sv
// Bundle between the PS/2 byte receiver / game logic (master) and key_move_scheduler (slave).
interface key_move_scheduler_if;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [15:0] keycode;
    logic        event_valid;
    logic [3:0]  held;
    logic        step_up;
    logic        step_down;
    logic        step_left;
    logic        step_right;

    modport master (
        output rx_byte, rx_valid,
        input  keycode, event_valid, held, step_up, step_down, step_left, step_right
    );

    modport slave (
        input  rx_byte, rx_valid,
        output keycode, event_valid, held, step_up, step_down, step_left, step_right
    );
endinterface

// File: rtl/key_move_scheduler.sv
// PS/2 byte sequencer with F0/E0 prefix FSM, held-key tracking and per-direction step scheduling.
// Define KEY_ARROWS_EN to alias the extended arrow keys onto the four direction bits.
//
// state     | meaning
// S_IDLE    | waiting for the first byte of a frame
// S_BRK     | F0 seen, next code byte is a break
// S_EXT     | E0 seen, next code byte is an extended make
// S_EXT_BRK | E0 and F0 both seen, next code byte is an extended break
module key_move_scheduler #(
    parameter int STEP_PERIOD    = 10000,
    parameter int PREFIX_TIMEOUT = 50000
) (
    input logic                 i_clk,
    input logic                 i_rst,
    key_move_scheduler_if.slave io_kbd
);
    localparam int TW = $clog2(PREFIX_TIMEOUT);
    localparam int SW = $clog2(STEP_PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_to_cnt;
    logic            w_to_hit;
    logic            w_evt;
    logic            w_brk;
    logic            w_ext;
    logic [3:0]      w_dir;
    logic [15:0]     r_keycode;
    logic            r_event_valid;
    logic [3:0]      r_held;
    logic [3:0]      w_active;
    logic [3:0]      r_act;
    logic [3:0]      r_step;
    logic [SW-1:0]   r_step_cnt [4];

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_evt    = 1'b0;
        w_brk    = 1'b0;
        w_ext    = 1'b0;
        w_to_hit = (r_to_cnt == TW'(PREFIX_TIMEOUT - 1));
        case (r_state)
            S_IDLE: begin
                if (io_kbd.rx_valid) begin
                    if (io_kbd.rx_byte == 8'hF0)      w_next = S_BRK;
                    else if (io_kbd.rx_byte == 8'hE0) w_next = S_EXT;
                    else                              w_evt  = 1'b1;
                end
            end
            S_BRK: begin
                if (io_kbd.rx_valid) begin
                    if (io_kbd.rx_byte == 8'hF0)      w_next = S_BRK;
                    else if (io_kbd.rx_byte == 8'hE0) w_next = S_EXT_BRK;
                    else begin
                        w_evt  = 1'b1;
                        w_brk  = 1'b1;
                        w_next = S_IDLE;
                    end
                end else if (w_to_hit) w_next = S_IDLE;
            end
            S_EXT: begin
                if (io_kbd.rx_valid) begin
                    if (io_kbd.rx_byte == 8'hF0)      w_next = S_EXT_BRK;
                    else if (io_kbd.rx_byte == 8'hE0) w_next = S_EXT;
                    else begin
                        w_evt  = 1'b1;
                        w_ext  = 1'b1;
                        w_next = S_IDLE;
                    end
                end else if (w_to_hit) w_next = S_IDLE;
            end
            S_EXT_BRK: begin
                if (io_kbd.rx_valid) begin
                    if (io_kbd.rx_byte != 8'hF0 && io_kbd.rx_byte != 8'hE0) begin
                        w_evt  = 1'b1;
                        w_brk  = 1'b1;
                        w_ext  = 1'b1;
                        w_next = S_IDLE;
                    end
                end else if (w_to_hit) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Idle time since the last byte of an open frame; parked at zero outside a frame.
    always_ff @(posedge i_clk) begin
        if (i_rst || io_kbd.rx_valid || w_next == S_IDLE) r_to_cnt <= '0;
        else                                               r_to_cnt <= r_to_cnt + 1'b1;
    end

    always_comb begin
        w_dir = 4'b0000;
        if (!w_ext) begin
            case (io_kbd.rx_byte)
                8'h1D:   w_dir = 4'b1000;
                8'h1B:   w_dir = 4'b0100;
                8'h1C:   w_dir = 4'b0010;
                8'h23:   w_dir = 4'b0001;
                default: w_dir = 4'b0000;
            endcase
        end else begin
`ifdef KEY_ARROWS_EN
            case (io_kbd.rx_byte)
                8'h75:   w_dir = 4'b1000;
                8'h72:   w_dir = 4'b0100;
                8'h6B:   w_dir = 4'b0010;
                8'h74:   w_dir = 4'b0001;
                default: w_dir = 4'b0000;
            endcase
`else
            w_dir = 4'b0000;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_keycode     <= '0;
            r_event_valid <= 1'b0;
            r_held        <= '0;
        end else begin
            r_event_valid <= w_evt;
            if (w_evt) begin
                r_keycode <= {(w_brk ? 8'hF0 : 8'h00), io_kbd.rx_byte};
                r_held    <= w_brk ? (r_held & ~w_dir) : (r_held | w_dir);
            end
        end
    end

    // A direction only schedules steps while its opposite is released.
    assign w_active = {r_held[3] & ~r_held[2], r_held[2] & ~r_held[3],
                       r_held[1] & ~r_held[0], r_held[0] & ~r_held[1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_act  <= '0;
            r_step <= '0;
            for (int i = 0; i < 4; i++) r_step_cnt[i] <= '0;
        end else begin
            r_act <= w_active;
            for (int i = 0; i < 4; i++) begin
                if (!w_active[i]) begin
                    r_step_cnt[i] <= '0;
                    r_step[i]     <= 1'b0;
                end else if (!r_act[i] || r_step_cnt[i] == SW'(STEP_PERIOD - 1)) begin
                    r_step_cnt[i] <= '0;
                    r_step[i]     <= 1'b1;
                end else begin
                    r_step_cnt[i] <= r_step_cnt[i] + 1'b1;
                    r_step[i]     <= 1'b0;
                end
            end
        end
    end

    assign io_kbd.keycode     = r_keycode;
    assign io_kbd.event_valid = r_event_valid;
    assign io_kbd.held        = r_held;
    assign io_kbd.step_up     = r_step[3];
    assign io_kbd.step_down   = r_step[2];
    assign io_kbd.step_left   = r_step[1];
    assign io_kbd.step_right  = r_step[0];
endmodule

// File: tb/tb_key_move_scheduler.sv
// Bench for key_move_scheduler: directed scenarios plus random byte traffic against a frame/step model.
module tb_key_move_scheduler;
    localparam int P = 40;
    localparam int T = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_move_scheduler_if kbd ();

    key_move_scheduler #(.STEP_PERIOD(P), .PREFIX_TIMEOUT(T)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_kbd (kbd)
    );

    int          checks = 0;
    int          errors = 0;
    int          n      = 0;
    bit          m_in, m_brk, m_ext;
    int          m_last;
    logic [15:0] m_key;
    bit          m_ev;
    logic [3:0]  m_held;
    bit   [3:0]  m_aprev;
    int          m_start [4];
    logic [3:0]  exp_step;
    logic [7:0]  pool [12] = '{8'hF0, 8'hF0, 8'hE0, 8'h1D, 8'h1B, 8'h1C,
                               8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};

    function automatic logic [3:0] dir_of(input logic [7:0] b, input bit ext);
        logic [3:0] d;
        d = 4'b0000;
        if (!ext) begin
            if (b == 8'h1D) d = 4'b1000;
            if (b == 8'h1B) d = 4'b0100;
            if (b == 8'h1C) d = 4'b0010;
            if (b == 8'h23) d = 4'b0001;
        end else begin
`ifdef KEY_ARROWS_EN
            if (b == 8'h75) d = 4'b1000;
            if (b == 8'h72) d = 4'b0100;
            if (b == 8'h6B) d = 4'b0010;
            if (b == 8'h74) d = 4'b0001;
`endif
        end
        return d;
    endfunction

    function automatic bit [3:0] active_of(input logic [3:0] h);
        bit [3:0] a;
        a[3] = h[3] && !h[2];
        a[2] = h[2] && !h[3];
        a[1] = h[1] && !h[0];
        a[0] = h[0] && !h[1];
        return a;
    endfunction

    task automatic tick(input bit v, input logic [7:0] b, input bit r);
        bit [3:0]   a;
        logic [3:0] d;
        logic [3:0] steps;
        kbd.rx_valid = v;
        kbd.rx_byte  = b;
        rst          = r;
        @(posedge clk);
        #1;
        n++;
        a = active_of(m_held);
        for (int i = 0; i < 4; i++) begin
            if (a[i] && !m_aprev[i]) m_start[i] = n - 1;
            exp_step[i] = a[i] && (((n - 1 - m_start[i]) % P) == 0);
        end
        m_aprev = a;
        m_ev    = 1'b0;
        if (r) begin
            m_in = 0; m_brk = 0; m_ext = 0;
            m_key = '0; m_held = '0; m_aprev = '0; exp_step = '0;
        end else begin
            if (m_in && !v && (n - m_last) >= T) begin
                m_in = 0; m_brk = 0; m_ext = 0;
            end
            if (v) begin
                if (b == 8'hF0) begin
                    m_brk = 1; m_in = 1; m_last = n;
                end else if (b == 8'hE0) begin
                    m_ext = 1; m_in = 1; m_last = n;
                end else begin
                    m_key  = {(m_brk ? 8'hF0 : 8'h00), b};
                    m_ev   = 1'b1;
                    d      = dir_of(b, m_ext);
                    m_held = m_brk ? (m_held & ~d) : (m_held | d);
                    m_in = 0; m_brk = 0; m_ext = 0;
                end
            end
        end
        steps = {kbd.step_up, kbd.step_down, kbd.step_left, kbd.step_right};
        checks++;
        assert (kbd.keycode === m_key) else begin
            errors++;
            $error("FAIL keycode cyc=%0d observed=%h expected=%h", n, kbd.keycode, m_key);
        end
        checks++;
        assert (kbd.event_valid === m_ev) else begin
            errors++;
            $error("FAIL event_valid cyc=%0d observed=%b expected=%b", n, kbd.event_valid, m_ev);
        end
        checks++;
        assert (kbd.held === m_held) else begin
            errors++;
            $error("FAIL held cyc=%0d observed=%b expected=%b", n, kbd.held, m_held);
        end
        checks++;
        assert (steps === exp_step) else begin
            errors++;
            $error("FAIL steps cyc=%0d observed=%b expected=%b", n, steps, exp_step);
        end
        kbd.rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_held(input string tag, input logic [3:0] want);
        checks++;
        assert (kbd.held === want) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, kbd.held, want);
        end
    endtask

    initial begin
        int up_count;
        kbd.rx_valid = 1'b0;
        kbd.rx_byte  = 8'h00;
        rst          = 1'b1;
        for (int i = 0; i < 4; i++) m_start[i] = 0;
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);
        idle(2);

        // Single press, repeats, release
        send(8'h1D);
        check_held("press_up", 4'b1000);
        idle(2 * P + 5);
        send(8'hF0); send(8'h1D);
        check_held("release_up", 4'b0000);
        idle(2 * P);

        // Timeout boundaries: byte in the timeout cycle is still a break; one later is a make
        send(8'h1B); idle(3);
        send(8'hF0); idle(T - 1); send(8'h1B);
        check_held("break_at_timeout_cycle", 4'b0000);
        idle(3);
        send(8'hF0); idle(T); send(8'h1B);
        check_held("make_after_timeout", 4'b0100);
        idle(5);
        send(8'hF0); send(8'h1B); idle(3);

        // Opposite conflict, then release of one side
        send(8'h1D); idle(50);
        send(8'h1B); idle(100);
        send(8'hF0); send(8'h1B); idle(60);
        send(8'hF0); send(8'h1D); idle(5);

        // Typematic repeats produce no extra steps
        up_count = 0;
        send(8'h1D);
        for (int k = 0; k < 2 * P + 2; k++) begin
            if (k == P / 3 || k == 2 * P / 3) send(8'h1D);
            else tick(1'b0, 8'h00, 1'b0);
            if (kbd.step_up) up_count++;
        end
        checks++;
        assert (up_count === 3) else begin
            errors++;
            $error("FAIL typematic_steps observed=%0d expected=%0d", up_count, 3);
        end
        send(8'hF0); send(8'h1D); idle(3);

        // Reset in mid-frame discards the F0
        send(8'hF0);
        tick(1'b0, 8'h00, 1'b1);
        send(8'h23);
        check_held("make_after_reset", 4'b0001);
        idle(P + 3);
        send(8'hF0); send(8'h23); idle(3);

        // Extended codes
        send(8'hE0); send(8'h74);
`ifdef KEY_ARROWS_EN
        check_held("ext_right", 4'b0001);
`else
        check_held("ext_right", 4'b0000);
`endif
        idle(P + 2);
        send(8'hE0); send(8'hF0); send(8'h74); idle(3);
        send(8'hE0); send(8'h75); idle(10);
        send(8'hF0); send(8'hE0); send(8'h75); idle(3);

        // Orthogonal keys together
        send(8'h1D); idle(3); send(8'h23); idle(2 * P + 3);
        send(8'hF0); send(8'h1D); idle(7);
        send(8'hF0); send(8'h23); idle(3);

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                idle(T + $urandom_range(0, 4));
            end else if ($urandom_range(0, 999) == 0) begin
                tick(1'b0, 8'h00, 1'b1);
            end else if ($urandom_range(0, 5) == 0) begin
                send(pool[$urandom_range(0, 11)]);
            end else begin
                tick(1'b0, 8'h00, 1'b0);
            end
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
